// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. It drives open-drain enables for the shared clock/data pair.
// Optional: define PS2_TX_TIMEOUT_EN to build the device-clock timeout and its path to FAIL.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_e;

  localparam logic [15:0] INH_LAST = 16'(INHIBIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  clk_s_q;   // [0],[1] synchronizer, [2] previous synced value
  logic [1:0]  data_s_q;
  logic        fall;
  logic [7:0]  byte_q, byte_d;
  logic        par_q, par_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] inh_q, inh_d;
  logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        to_expired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s_q  <= '1;
      data_s_q <= '1;
    end else begin
      clk_s_q  <= {clk_s_q[1:0], ps2_clk_in};
      data_s_q <= {data_s_q[0], ps2_data_in};
    end
  end

  assign fall = clk_s_q[2] & ~clk_s_q[1];

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] to_q;

  // A fall always clears, so it wins over an expiry in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      to_q <= '0;
    else if (fall || !(state_q inside {S_SEND, S_ACK, S_WAIT_IDLE}))
      to_q <= '0;
    else
      to_q <= to_q + 20'd1;
  end

  assign to_expired = (to_q == TO_LAST) && !fall;
`else
  assign to_expired = 1'b0;
  // TIMEOUT_CYCLES stays in the parameter list so both builds share one interface.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      byte_q    <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      inh_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    par_d     = par_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // busy_q is still high in the done/error cycle; the next start waits for it to drop.
        if (tx_start && !busy_q) begin
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          inh_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) state_d = S_START;
        else                   inh_d   = inh_q + 16'd1;
      end
      S_START: begin
        bit_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          if (bit_q < 4'd8)       data_oe_d = ~byte_q[bit_q[2:0]];
          else if (bit_q == 4'd8) data_oe_d = ~par_q;
          else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
          bit_d = bit_q + 4'd1;
        end else if (to_expired) begin
          state_d = S_FAIL;
        end
      end
      S_ACK: begin
        if (fall)            state_d = data_s_q[1] ? S_FAIL : S_WAIT_IDLE;
        else if (to_expired) state_d = S_FAIL;
      end
      S_WAIT_IDLE: begin
        if (clk_s_q[1] && data_s_q[1]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (to_expired) begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Data is held low from START until the first device fall (start bit).
    if (state_d == S_START)     data_oe_d = 1'b1;
    else if (state_d != S_SEND) data_oe_d = 1'b0;
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
    busy_d   = (state_d != S_IDLE) || done_d || error_d;
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out and a queue holds expected line bits.
module tb_ps2_host_tx;
  localparam int INH  = 40;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       clk_line, data_line;

  int checks = 0, passed = 0;
  int done_cnt = 0, err_cnt = 0, cyc = 0;
  logic [9:0] exp_q[$];

  assign clk_line  = dev_clk  & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .tx_data(tx_data), .tx_start(tx_start), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (done === 1'b1)  done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt  <= err_cnt + 1;
  end

  initial begin
    repeat (200000) @(posedge clock);
    $display("FAIL watchdog: cycle budget exhausted, got no end want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (ps2_clk_oe !== 1'b0)  $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe);  else passed++;
    checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else passed++;
    checks++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy);          else passed++;
    checks++; if (done !== 1'b0)        $display("FAIL reset_done: got %b want 0", done);          else passed++;
    checks++; if (error !== 1'b0)       $display("FAIL reset_error: got %b want 0", error);        else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Full frame: start, inhibit window, 10 device-clocked bits, ACK/NACK, result pulse.
  task automatic test_frame(input string name, input logic [7:0] d, input bit ack, input bit poke);
    int win, w, d0, e0;
    logic [9:0] got, exp;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back({1'b1, ~^d, d});
    @(negedge clock); tx_data = d; tx_start = 1'b1;
    @(negedge clock); tx_start = 1'b0; tx_data = 8'h00;
    checks++; if (busy !== 1'b1) $display("FAIL %s busy_rise: got %b want 1", name, busy); else passed++;
    win = 0;
    while (ps2_clk_oe === 1'b1 && win < INH + 50) begin win++; @(negedge clock); end
    checks++; if (win != INH + 1) $display("FAIL %s clk_oe_window: got %0d want %0d", name, win, INH + 1); else passed++;
    checks++; if (ps2_data_oe !== 1'b1) $display("FAIL %s start_bit: got oe %b want 1", name, ps2_data_oe); else passed++;
    got = '0;
    for (int i = 0; i < 10; i++) begin
      repeat (HALF) @(negedge clock); dev_clk = 1'b0;
      if (poke && i == 4) begin
        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge clock); tx_start = 1'b0; tx_data = 8'h00;
      end
      repeat (HALF) @(negedge clock); got[i] = data_line; dev_clk = 1'b1;
    end
    exp = exp_q.pop_front();
    checks++; if (got !== exp) $display("FAIL %s frame_bits: got %b want %b", name, got, exp); else passed++;
    repeat (HALF) @(negedge clock); if (ack) dev_data = 1'b0;
    repeat (HALF) @(negedge clock); dev_clk = 1'b0;
    repeat (HALF) @(negedge clock); dev_clk = 1'b1; dev_data = 1'b1;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 500) begin w++; @(negedge clock); end
    repeat (3) @(negedge clock);
    checks++; if (done_cnt - d0 != (ack ? 1 : 0)) $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, ack ? 1 : 0); else passed++;
    checks++; if (err_cnt - e0 != (ack ? 0 : 1))  $display("FAIL %s error_pulses: got %0d want %0d", name, err_cnt - e0, ack ? 0 : 1); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s busy_after: got %b want 0", name, busy); else passed++;
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL %s oe_after: got %b want 00", name, {ps2_clk_oe, ps2_data_oe}); else passed++;
    if (poke) begin
      repeat (INH + 10) @(negedge clock);
      checks++; if (busy !== 1'b0) $display("FAIL %s ignored_start_relaunch: got busy %b want 0", name, busy); else passed++;
    end
  endtask

  // Device stops after 4 clocks.
  task automatic test_stall();
    int w, d0, e0, last;
    d0 = done_cnt; e0 = err_cnt; last = 0;
    @(negedge clock); tx_data = 8'h55; tx_start = 1'b1;
    @(negedge clock); tx_start = 1'b0;
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < INH + 50) begin w++; @(negedge clock); end
    while (ps2_clk_oe === 1'b0 && busy === 1'b1 && ps2_data_oe !== 1'b1 && w < INH + 60) begin w++; @(negedge clock); end
    for (int i = 0; i < 4; i++) begin
      repeat (HALF) @(negedge clock); dev_clk = 1'b0; last = cyc;
      repeat (HALF) @(negedge clock); dev_clk = 1'b1;
    end
`ifdef PS2_TX_TIMEOUT_EN
    w = 0;
    while (err_cnt == e0 && w < 3 * TO) begin w++; @(negedge clock); end
    checks++; if (err_cnt - e0 != 1) $display("FAIL timeout_error: got %0d pulses want 1", err_cnt - e0); else passed++;
    checks++; if (cyc - last < TO || cyc - last > TO + 10) $display("FAIL timeout_latency: got %0d want %0d..%0d", cyc - last, TO, TO + 10); else passed++;
    repeat (3) @(negedge clock);
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); else passed++;
    checks++; if (busy !== 1'b0 || done_cnt != d0) $display("FAIL timeout_idle: got busy %b done %0d want 0 0", busy, done_cnt - d0); else passed++;
`else
    repeat (TO + 500) @(negedge clock);
    checks++; if (err_cnt != e0) $display("FAIL stall_no_error: got %0d pulses want 0", err_cnt - e0); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL stall_still_busy: got %b want 1", busy); else passed++;
    #2 reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL stall_recover: got busy %b want 0", busy); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clock); tx_data = 8'h5A; tx_start = 1'b1;
    @(negedge clock); tx_start = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (ps2_clk_oe !== 1'b1) $display("FAIL mid_inhibit_clk_oe: got %b want 1", ps2_clk_oe); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL async_reset_clk_oe: got %b want 0", ps2_clk_oe); else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL async_reset_busy: got %b want 0", busy);       else passed++;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    test_frame("after_reset_FF", 8'hFF, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame("send_ED",   8'hED, 1'b1, 1'b0);
    test_frame("parity_01", 8'h01, 1'b1, 1'b0);
    test_frame("parity_00", 8'h00, 1'b1, 1'b0);
    test_frame("nack_A5",   8'hA5, 1'b0, 1'b0);
    test_frame("ignored_start_3C", 8'h3C, 1'b1, 1'b1);
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
